// File: rtl/bt_uart_rx_fifo_if.sv
// Reader-side bundle of the BT UART receiver: FIFO pop port, fill level and sticky error flags.
// The reader drives the master modport and the receiver implements the slave modport.
interface bt_uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          rd_en;
    logic [DATA_BITS-1:0]          rd_data;
    logic                          rd_valid;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overrun_err;
    logic                          frame_err;
    logic                          parity_err;
    logic                          err_clr;

    modport master (
        output rd_en,
        output err_clr,
        input  rd_data,
        input  rd_valid,
        input  fifo_count,
        input  overrun_err,
        input  frame_err,
        input  parity_err
    );

    modport slave (
        input  rd_en,
        input  err_clr,
        output rd_data,
        output rd_valid,
        output fifo_count,
        output overrun_err,
        output frame_err,
        output parity_err
    );
endinterface

// File: rtl/bt_uart_rx_fifo.sv
// Receiver for the Bluetooth serial link: configurable width and parity, with a show-ahead FIFO
// and sticky error flags.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for a synchronised low level
// START     | half-bit wait, then confirm the start bit (glitch filter)
// DATA      | sample DATA_BITS data bits, LSB first, one per bit period
// PARITY    | sample the parity bit and record a mismatch
// STOP      | sample the stop bit; push, or raise parity/frame error
// WAIT_IDLE | after a framing error, wait for the line to return high
module bt_uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              bt_uart_rxd,
    bt_uart_rx_fifo_if.slave  rd_if
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic          PAR_ODD   = (PARITY_MODE == 1);
    localparam logic          PAR_EN    = (PARITY_MODE != 0);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    logic                 rxd_s1;
    logic                 rxd_s2;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 bad_parity;

    logic                 tick;
    logic                 stop_hit;
    logic                 push_req;
    logic                 frame_set;
    logic                 parity_set;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 not_empty;
    logic                 pop;
    logic                 full_after_pop;
    logic                 do_push;
    logic                 overrun_set;

    logic                 overrun_q;
    logic                 frame_q;
    logic                 parity_q;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
        end else begin
            rxd_s1 <= bt_uart_rxd;
            rxd_s2 <= rxd_s1;
        end
    end

    assign tick       = (cnt == CNT_LAST);
    assign stop_hit   = (state == ST_STOP) && tick;
    assign push_req   = stop_hit && rxd_s2 && !bad_parity;
    assign parity_set = stop_hit && rxd_s2 && bad_parity;
    assign frame_set  = stop_hit && !rxd_s2;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            bad_parity <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rxd_s2) state <= ST_START;
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt        <= '0;
                        bit_idx    <= '0;
                        bad_parity <= 1'b0;
                        state      <= rxd_s2 ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        cnt     <= '0;
                        shreg   <= {rxd_s2, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST) state <= PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        cnt        <= '0;
                        bad_parity <= ((^shreg) ^ rxd_s2) != PAR_ODD;
                        state      <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= rxd_s2 ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    cnt <= '0;
                    if (rxd_s2) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Full is judged after this cycle's pop, so a push coinciding with a pop never overruns.
    assign not_empty      = (count != '0);
    assign pop            = rd_if.rd_en && not_empty;
    assign full_after_pop = (count == FULL_CNT) && !pop;
    assign do_push        = push_req && !full_after_pop;
    assign overrun_set    = push_req && full_after_pop;

    always_ff @(posedge clk_clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new error in the same cycle as err_clr wins.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
            parity_q  <= 1'b0;
        end else begin
            overrun_q <= (overrun_q && !rd_if.err_clr) || overrun_set;
            frame_q   <= (frame_q   && !rd_if.err_clr) || frame_set;
            parity_q  <= (parity_q  && !rd_if.err_clr) || parity_set;
        end
    end

    assign rd_if.rd_valid    = not_empty;
    assign rd_if.rd_data     = not_empty ? mem[rd_ptr] : '0;
    assign rd_if.fifo_count  = count;
    assign rd_if.overrun_err = overrun_q;
    assign rd_if.frame_err   = frame_q;
    assign rd_if.parity_err  = parity_q;
endmodule

// File: tb/tb_bt_uart_rx_fifo.sv
// Self-checking bench: an 8N1 receiver and an even-parity receiver, driven with serial frames
// and checked through a scoreboard of expected FIFO contents.
module tb_bt_uart_rx_fifo;
    localparam int CPB   = 16;
    localparam int HALF  = CPB / 2;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int STOP_8N1 = 2 + HALF + 9 * CPB;
    localparam int STOP_8E1 = 2 + HALF + 10 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd_n = 1'b1;
    logic rxd_e = 1'b1;

    always #5 clk = ~clk;

    bt_uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) if_n ();
    bt_uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) if_e ();

    bt_uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_MODE(0), .FIFO_DEPTH(DEPTH)) u_n (
        .clk_clk(clk), .reset_reset_n(rst_n), .bt_uart_rxd(rxd_n), .rd_if(if_n));
    bt_uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_MODE(2), .FIFO_DEPTH(DEPTH)) u_e (
        .clk_clk(clk), .reset_reset_n(rst_n), .bt_uart_rxd(rxd_e), .rd_if(if_e));

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] q_n[$];
    logic [7:0] q_e[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       ok;
        logic       clr_at_stop;
    } pvec_t;
    pvec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input bit sel_e, input logic b);
        if (sel_e) rxd_e = b;
        else       rxd_n = b;
    endtask

    task automatic send_frame(input bit sel_e, input logic [7:0] data, input bit with_par, input logic par);
        set_rx(sel_e, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            set_rx(sel_e, data[i]);
            repeat (CPB) @(negedge clk);
        end
        if (with_par) begin
            set_rx(sel_e, par);
            repeat (CPB) @(negedge clk);
        end
        set_rx(sel_e, 1'b1);
        repeat (CPB + 4) @(negedge clk);
    endtask

    task automatic pop_one(input bit sel_e);
        logic [7:0] exp;
        if (sel_e) begin
            check("sb_nonempty_e", (q_e.size() != 0), 1);
            exp = (q_e.size() != 0) ? q_e.pop_front() : 8'h00;
            check("rd_valid_e", if_e.rd_valid, 1);
            check("rd_data_e", if_e.rd_data, exp);
            if_e.rd_en = 1'b1;
            @(negedge clk);
            if_e.rd_en = 1'b0;
        end else begin
            check("sb_nonempty_n", (q_n.size() != 0), 1);
            exp = (q_n.size() != 0) ? q_n.pop_front() : 8'h00;
            check("rd_valid_n", if_n.rd_valid, 1);
            check("rd_data_n", if_n.rd_data, exp);
            if_n.rd_en = 1'b1;
            @(negedge clk);
            if_n.rd_en = 1'b0;
        end
    endtask

    task automatic clr_n();
        if_n.err_clr = 1'b1;
        @(negedge clk);
        if_n.err_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{data: 8'h03, par: 1'b1, ok: 1'b0, clr_at_stop: 1'b0};
        vt[1] = '{data: 8'h03, par: 1'b0, ok: 1'b1, clr_at_stop: 1'b0};
        vt[2] = '{data: 8'h07, par: 1'b1, ok: 1'b1, clr_at_stop: 1'b0};
        vt[3] = '{data: 8'hA5, par: 1'b1, ok: 1'b0, clr_at_stop: 1'b1};
        vt[4] = '{data: 8'hFF, par: 1'b0, ok: 1'b1, clr_at_stop: 1'b0};
        vt[5] = '{data: 8'h80, par: 1'b0, ok: 1'b0, clr_at_stop: 1'b0};

        if_n.rd_en = 1'b0; if_n.err_clr = 1'b0;
        if_e.rd_en = 1'b0; if_e.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count_n", if_n.fifo_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid_n", if_n.rd_valid, 0);
        check("rst_data_n", if_n.rd_data, 0);
        check("rst_overrun_n", if_n.overrun_err, 0);
        check("rst_frame_n", if_n.frame_err, 0);
        check("rst_parity_n", if_n.parity_err, 0);
        check("rst_valid_e", if_e.rd_valid, 0);

        // Basic 8N1 reception
        send_frame(0, 8'hA5, 0, 1'b0);
        q_n.push_back(8'hA5);
        check("t1_count", if_n.fifo_count, 1);
        pop_one(0);
        check("t1_valid_after_pop", if_n.rd_valid, 0);
        check("t1_count_after_pop", if_n.fifo_count, 0);
        if_n.rd_en = 1'b1;
        @(negedge clk);
        if_n.rd_en = 1'b0;
        check("empty_pop_count", if_n.fifo_count, 0);

        // Even parity table
        for (int k = 0; k < 6; k++) begin
            fork
                send_frame(1, vt[k].data, 1, vt[k].par);
                begin
                    if (vt[k].clr_at_stop) begin
                        repeat (STOP_8E1) @(negedge clk);
                        if_e.err_clr = 1'b1;
                        @(negedge clk);
                        if_e.err_clr = 1'b0;
                    end
                end
            join
            if (vt[k].ok) q_e.push_back(vt[k].data);
            check("par_err_flag", if_e.parity_err, !vt[k].ok);
            check("par_count", if_e.fifo_count, vt[k].ok ? 1 : 0);
            check("par_frame_err", if_e.frame_err, 0);
            if (vt[k].ok) pop_one(1);
            if_e.err_clr = 1'b1;
            @(negedge clk);
            if_e.err_clr = 1'b0;
            check("par_err_cleared", if_e.parity_err, 0);
        end

        // Overrun: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            send_frame(0, 8'(i), 0, 1'b0);
            if (i < DEPTH) q_n.push_back(8'(i));
        end
        check("ovr_count", if_n.fifo_count, DEPTH);
        check("ovr_flag", if_n.overrun_err, 1);
        clr_n();
        check("ovr_cleared", if_n.overrun_err, 0);

        // Pop coinciding with the stop-bit push while full
        fork
            send_frame(0, 8'h11, 0, 1'b0);
            begin
                repeat (STOP_8N1) @(negedge clk);
                check("coinc_data", if_n.rd_data, (q_n.size() != 0) ? q_n.pop_front() : 8'hxx);
                if_n.rd_en = 1'b1;
                @(negedge clk);
                if_n.rd_en = 1'b0;
            end
        join
        q_n.push_back(8'h11);
        check("coinc_count", if_n.fifo_count, DEPTH);
        check("coinc_overrun", if_n.overrun_err, 0);
        for (int i = 0; i < DEPTH; i++) pop_one(0);
        check("drain_count", if_n.fifo_count, 0);

        // Break: three frame times low
        set_rx(0, 1'b0);
        repeat (11 * CPB) @(negedge clk);
        check("brk_frame_err", if_n.frame_err, 1);
        check("brk_count", if_n.fifo_count, 0);
        clr_n();
        repeat (19 * CPB) @(negedge clk);
        set_rx(0, 1'b1);
        repeat (4 * CPB) @(negedge clk);
        check("brk_single_err", if_n.frame_err, 0);
        check("brk_no_push", if_n.fifo_count, 0);
        send_frame(0, 8'h5A, 0, 1'b0);
        q_n.push_back(8'h5A);
        pop_one(0);
        check("brk_frame_err_after", if_n.frame_err, 0);

        // Short glitch on the idle line
        set_rx(0, 1'b0);
        repeat (CPB / 4) @(negedge clk);
        set_rx(0, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("glitch_count", if_n.fifo_count, 0);
        check("glitch_frame", if_n.frame_err, 0);
        check("glitch_parity", if_n.parity_err, 0);
        check("glitch_overrun", if_n.overrun_err, 0);

        // Reset mid-DATA with one byte buffered
        send_frame(0, 8'h33, 0, 1'b0);
        check("pre_rst_count", if_n.fifo_count, 1);
        set_rx(0, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_count", if_n.fifo_count, 0);
        check("mid_rst_valid", if_n.rd_valid, 0);
        check("mid_rst_data", if_n.rd_data, 0);
        q_n.delete();
        set_rx(0, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);
        check("post_rst_count", if_n.fifo_count, 0);
        send_frame(0, 8'hC3, 0, 1'b0);
        q_n.push_back(8'hC3);
        check("post_rst_one", if_n.fifo_count, 1);
        pop_one(0);
        check("post_rst_empty", if_n.fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
